// File: rtl/thumb_prefetch_queue.sv
// -----------------------------------------------------------------------------
// thumb_prefetch_queue
//
// Instruction prefetch queue for a dual-issue Thumb decoder. Fetches FETCH_HW
// halfwords per access from a synchronous program memory (1-cycle latency)
// into a circular halfword queue, and presents the two oldest halfwords to
// the decoder. The decoder retires 0/1/2 halfwords per cycle. A flush
// redirects fetch to any halfword address, including odd (unaligned) ones.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_req/mem_addr  memory read request and FETCH_HW-aligned halfword addr
//   mem_rdata         read data, one cycle after mem_req, [15:0] = lowest addr
//   consume           halfwords retired by the decoder this cycle (0..2)
//   flush/flush_addr  discard queue contents and redirect fetch
//   IR_0/IR_1         oldest / second-oldest halfword (16'h0 when invalid)
//   valid_0/valid_1   slot valid flags (count >= 1 / count >= 2)
//   head_addr         halfword address of IR_0
// -----------------------------------------------------------------------------
module thumb_prefetch_queue #(
    parameter int ADDR_W     = 14,
    parameter int DEPTH      = 8,
    parameter int FETCH_HW   = 2,
    parameter int RESET_ADDR = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [16*FETCH_HW-1:0]  mem_rdata,
    input  logic [1:0]              consume,
    input  logic                    flush,
    input  logic [ADDR_W-1:0]       flush_addr,
    output logic [15:0]             IR_0,
    output logic [15:0]             IR_1,
    output logic                    valid_0,
    output logic                    valid_1,
    output logic [ADDR_W-1:0]       head_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(FETCH_HW - 1);
    localparam logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_ADDR) & ALIGN_MASK;
    localparam logic              RESET_SKIP = (FETCH_HW == 2) && ((RESET_ADDR % 2) == 1);

    localparam logic [CNT_W-1:0]  FETCH_CNT  = CNT_W'(FETCH_HW);
    localparam logic [OCC_W-1:0]  FETCH_OCC  = OCC_W'(FETCH_HW);
    // Highest occupancy (after this cycle's consume, including reserved
    // in-flight slots) that still leaves room for one more full access.
    localparam logic [OCC_W-1:0]  ISSUE_LIMIT = OCC_W'(DEPTH - FETCH_HW);

    // State
    logic                    run_q,           run_d;
    logic [CNT_W-1:0]        count_q,         count_d;
    logic [PTR_W-1:0]        rd_ptr_q,        rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q,        wr_ptr_d;
    logic [ADDR_W-1:0]       head_addr_q,     head_addr_d;
    logic [ADDR_W-1:0]       fetch_pc_q,      fetch_pc_d;
    logic                    inflight_q,      inflight_d;
    logic                    skip_lo_q,       skip_lo_d;
    logic                    skip_inflight_q, skip_inflight_d;
    logic [15:0]             queue_q [DEPTH];
    logic [15:0]             queue_d [DEPTH];

    // Combinational helpers
    logic [CNT_W-1:0]        consumed;
    logic [CNT_W-1:0]        pushed;
    logic [OCC_W-1:0]        occupied_after;
    logic [PTR_W-1:0]        wr_idx;
    logic [PTR_W-1:0]        rd_idx1;

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block so that no path leaves it unassigned (no latches).
    always_comb begin
        // Decoder may over-ask; never retire more than is actually queued.
        consumed = (CNT_W'(consume) > count_q) ? count_q : CNT_W'(consume);

        // Response arriving this cycle is already counted via inflight_q, so
        // the next request is only issued if a full access will fit.
        occupied_after = {1'b0, count_q} - {1'b0, consumed}
                       + (inflight_q ? FETCH_OCC : '0);
        mem_req = run_q && !flush && (occupied_after <= ISSUE_LIMIT);

        // An odd redirect target drops the lower halfword of the first access.
        pushed = inflight_q ? (skip_inflight_q ? FETCH_CNT - CNT_W'(1) : FETCH_CNT)
                            : '0;

        run_d           = 1'b1;
        count_d         = count_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        head_addr_d     = head_addr_q;
        fetch_pc_d      = fetch_pc_q;
        inflight_d      = inflight_q;
        skip_lo_d       = skip_lo_q;
        skip_inflight_d = skip_inflight_q;
        queue_d         = queue_q;
        wr_idx          = '0;

        if (flush) begin
            // Redirect wins over consume, push and issue; the response that
            // lands in this cycle is discarded by clearing inflight.
            count_d         = '0;
            rd_ptr_d        = '0;
            wr_ptr_d        = '0;
            head_addr_d     = flush_addr;
            fetch_pc_d      = flush_addr & ALIGN_MASK;
            skip_lo_d       = (FETCH_HW == 2) && flush_addr[0];
            inflight_d      = 1'b0;
            skip_inflight_d = 1'b0;
        end else begin
            if (inflight_q) begin
                for (int i = 0; i < FETCH_HW; i++) begin
                    if (!(skip_inflight_q && (i == 0))) begin
                        wr_idx = wr_ptr_q + PTR_W'(i) - PTR_W'(skip_inflight_q);
                        queue_d[wr_idx] = mem_rdata[16*i +: 16];
                    end
                end
            end
            count_d     = count_q + pushed - consumed;
            rd_ptr_d    = rd_ptr_q + consumed[PTR_W-1:0];
            wr_ptr_d    = wr_ptr_q + pushed[PTR_W-1:0];
            head_addr_d = head_addr_q + ADDR_W'(consumed);
            inflight_d  = mem_req;
            // Remember whether this request carries a skipped lower halfword.
            skip_inflight_d = mem_req && skip_lo_q;
            if (mem_req) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(FETCH_HW);
                skip_lo_d  = 1'b0;
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q           <= 1'b0;
            count_q         <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            head_addr_q     <= ADDR_W'(RESET_ADDR);
            fetch_pc_q      <= RESET_PC;
            inflight_q      <= 1'b0;
            skip_lo_q       <= RESET_SKIP;
            skip_inflight_q <= 1'b0;
        end else begin
            run_q           <= run_d;
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            head_addr_q     <= head_addr_d;
            fetch_pc_q      <= fetch_pc_d;
            inflight_q      <= inflight_d;
            skip_lo_q       <= skip_lo_d;
            skip_inflight_q <= skip_inflight_d;
        end
    end

    // NOTE: the halfword storage is deliberately not reset; count_q gates
    // every read, so stale contents are never observable.
    always_ff @(posedge clk) begin
        queue_q <= queue_d;
    end

    // Read side
    assign rd_idx1   = rd_ptr_q + PTR_W'(1);
    assign valid_0   = (count_q != '0);
    assign valid_1   = (count_q > CNT_W'(1));
    assign IR_0      = valid_0 ? queue_q[rd_ptr_q] : 16'h0;
    assign IR_1      = valid_1 ? queue_q[rd_idx1]  : 16'h0;
    assign mem_addr  = fetch_pc_q;
    assign head_addr = head_addr_q;

endmodule

// File: tb/tb_thumb_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_thumb_prefetch_queue
//
// Self-checking bench for thumb_prefetch_queue (default parameters). A
// synchronous program-memory model answers requests. Whenever the bench
// redirects the fetch stream (reset or flush) it pushes the expected
// halfword stream into a scoreboard queue; entries are popped and compared
// as the decoder side retires halfwords. Fetch addresses are tracked by a
// small expected-PC model.
// -----------------------------------------------------------------------------
module tb_thumb_prefetch_queue;

    localparam int ADDR_W   = 14;
    localparam int FETCH_HW = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } sb_entry_t;

    logic                   clk;
    logic                   rst_n;
    logic                   mem_req;
    logic [ADDR_W-1:0]      mem_addr;
    logic [16*FETCH_HW-1:0] mem_rdata;
    logic [1:0]             consume;
    logic                   flush;
    logic [ADDR_W-1:0]      flush_addr;
    logic [15:0]            IR_0;
    logic [15:0]            IR_1;
    logic                   valid_0;
    logic                   valid_1;
    logic [ADDR_W-1:0]      head_addr;

    int                     n_vec  = 0;
    int                     n_miss = 0;
    sb_entry_t              exp_q[$];
    logic [ADDR_W-1:0]      exp_fetch;

    thumb_prefetch_queue #(
        .ADDR_W(ADDR_W), .DEPTH(8), .FETCH_HW(FETCH_HW), .RESET_ADDR(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .consume(consume), .flush(flush), .flush_addr(flush_addr),
        .IR_0(IR_0), .IR_1(IR_1), .valid_0(valid_0), .valid_1(valid_1),
        .head_addr(head_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory contents
    function automatic logic [15:0] prog(input logic [ADDR_W-1:0] a);
        case (a)
            14'd0:   return 16'h2070;
            14'd1:   return 16'h2170;
            14'd2:   return 16'h1842;
            14'd3:   return 16'h0600;
            default: return 16'h4000 | {2'b00, a};
        endcase
    endfunction

    // Synchronous memory: data valid the cycle after the request
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= {prog(mem_addr + 14'd1), prog(mem_addr)};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // New fetch stream starting at addr: refill the expected halfword stream.
    task automatic redirect(input logic [ADDR_W-1:0] addr);
        sb_entry_t e;
        exp_q.delete();
        for (int i = 0; i < 128; i++) begin
            e.addr = addr + ADDR_W'(i);
            e.data = prog(e.addr);
            exp_q.push_back(e);
        end
        exp_fetch = addr & ~ADDR_W'(FETCH_HW - 1);
    endtask

    // One decoder cycle. Entered #1 after a rising edge; returns #1 after the
    // next one. req_exp / v_exp: -1 means don't care, v_exp = {valid_1,valid_0}.
    task automatic step(input logic [1:0] k, input int req_exp, input int v_exp);
        int n;
        int eff;
        consume = k;
        flush   = 1'b0;
        @(negedge clk);
        if (req_exp >= 0) check("mem_req", 32'(mem_req), 32'(req_exp));
        if (v_exp >= 0)   check("valids", {30'b0, valid_1, valid_0}, 32'(v_exp));
        if (mem_req) begin
            check("fetch_addr", 32'(mem_addr), 32'(exp_fetch));
            exp_fetch = exp_fetch + ADDR_W'(FETCH_HW);
        end
        check("valid_order", 32'(valid_1 & ~valid_0), 32'd0);
        check("head_addr", 32'(head_addr), 32'(exp_q[0].addr));
        if (valid_0) check("IR_0", 32'(IR_0), 32'(exp_q[0].data));
        else         check("IR_0_idle", 32'(IR_0), 32'd0);
        if (valid_1) check("IR_1", 32'(IR_1), 32'(exp_q[1].data));
        else         check("IR_1_idle", 32'(IR_1), 32'd0);
        n   = int'(valid_0) + int'(valid_1);
        eff = (int'(k) > n) ? n : int'(k);
        for (int i = 0; i < eff; i++) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [ADDR_W-1:0] addr);
        consume    = 2'd2;
        flush      = 1'b1;
        flush_addr = addr;
        @(negedge clk);
        check("flush_req", 32'(mem_req), 32'd0);
        redirect(addr);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        consume = 2'd0;
    endtask

    task automatic startup();
        @(negedge clk);
        rst_n = 1'b1;
        redirect(14'd0);
        check("req_c0", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        step(2'd0, 1, 0);
        step(2'd0, 1, 0);
        step(2'd0, 1, 3);
    endtask

    initial begin
        rst_n      = 1'b0;
        consume    = 2'd0;
        flush      = 1'b0;
        flush_addr = '0;
        exp_fetch  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valids", {30'b0, valid_1, valid_0}, 32'd0);
        check("rst_IR_0", 32'(IR_0), 32'd0);
        check("rst_IR_1", 32'(IR_1), 32'd0);
        check("rst_head", 32'(head_addr), 32'd0);

        // Fill from reset with no consumption until the queue is full.
        startup();
        step(2'd0, 1, 3);
        repeat (5) step(2'd0, 0, 3);

        // Streaming from full: two per cycle, no bubbles.
        repeat (12) step(2'd2, 1, 3);

        // Single-halfword retirement: head_addr goes odd.
        repeat (3) step(2'd1, -1, 3);
        step(2'd2, 1, 3);

        // Redirect to an odd target with a response in flight.
        do_flush(14'd5);
        step(2'd0, 1, 0);
        step(2'd0, 1, 0);
        step(2'd2, -1, 1);   // only halfword@5 queued, over-ask clamps to 1
        step(2'd1, -1, -1);

        // Mixed consumption across several pointer wraps.
        repeat (40) step(2'($urandom_range(0, 2)), -1, -1);

        // Fill to full, then reset asynchronously mid-cycle.
        repeat (8) step(2'd0, -1, -1);
        step(2'd0, 0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valids", {30'b0, valid_1, valid_0}, 32'd0);
        check("async_mem_req", 32'(mem_req), 32'd0);
        check("async_IR_0", 32'(IR_0), 32'd0);
        check("async_head", 32'(head_addr), 32'd0);
        @(posedge clk);
        startup();
        repeat (6) step(2'd2, -1, 3);
        repeat (10) step(2'($urandom_range(0, 2)), -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
